vend_ctrl_param: RTL



---
 rtl/vend_ctrl_param.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/vend_ctrl_param.sv
// Parametrised coin-vending controller: accumulates credit, dispenses through a
// valid/ready handshake, then pays change or a refund through a second handshake.
module vend_ctrl_param #(
  parameter int unsigned PRICE       = 30,
  parameter int unsigned COIN_A      = 5,
  parameter int unsigned COIN_B      = 10,
  parameter int unsigned COIN_C      = 25,
  parameter int unsigned CREDIT_W    = 6,
  parameter int unsigned TIMEOUT_CYC = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          in_i,
  input  logic                confirm_i,
  output logic                vend_valid_o,
  input  logic                vend_ready_i,
  output logic                pay_valid_o,
  output logic [CREDIT_W-1:0] pay_amt_o,
  output logic                pay_kind_o,
  input  logic                pay_ready_i,
  output logic [CREDIT_W-1:0] credit_o,
  output logic                busy_o,
  output logic [1:0]          out_o
);

  localparam int unsigned SUM_W = CREDIT_W + 1;
  localparam int unsigned TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_CANCEL = 2'b01;
  localparam logic [1:0] ST_EXACT  = 2'b10;
  localparam logic [1:0] ST_CHANGE = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_VEND,
    S_PAYOUT
  } state_e;

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] pay_amt_q, pay_amt_d;
  logic                pay_kind_q, pay_kind_d;
  logic                vend_valid_q, vend_valid_d;
  logic                pay_valid_q, pay_valid_d;
  logic                busy_q, busy_d;
  logic [1:0]          out_q, out_d;
  logic [TMR_W-1:0]    timer_q, timer_d;

  logic [SUM_W-1:0]    coin_val;
  logic [SUM_W-1:0]    sum;
  logic                timeout;

  // Sum is one bit wider than credit so the price comparison cannot wrap.
  always_comb begin
    coin_val = '0;
    case (in_i)
      2'b01:   coin_val = SUM_W'(COIN_A);
      2'b10:   coin_val = SUM_W'(COIN_B);
      2'b11:   coin_val = SUM_W'(COIN_C);
      default: coin_val = '0;
    endcase
    sum     = {1'b0, credit_q} + coin_val;
    timeout = (TIMEOUT_CYC != 0) && (state_q == S_ACCUM) && !confirm_i &&
              (timer_q == TMR_W'(TIMEOUT_CYC - 1));
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    credit_d     = credit_q;
    pay_amt_d    = pay_amt_q;
    pay_kind_d   = pay_kind_q;
    vend_valid_d = vend_valid_q;
    pay_valid_d  = pay_valid_q;
    busy_d       = busy_q;
    out_d        = out_q;
    timer_d      = timer_q;

    case (state_q)
      S_IDLE, S_ACCUM: begin
        if (confirm_i && (in_i != 2'b00)) begin
          timer_d = '0;
          if (sum < SUM_W'(PRICE)) begin
            credit_d = CREDIT_W'(sum);
            state_d  = S_ACCUM;
          end else begin
            pay_amt_d    = CREDIT_W'(sum - SUM_W'(PRICE));
            pay_kind_d   = 1'b0;
            credit_d     = '0;
            state_d      = S_VEND;
            vend_valid_d = 1'b1;
            busy_d       = 1'b1;
            out_d        = (sum == SUM_W'(PRICE)) ? ST_EXACT : ST_CHANGE;
          end
        end else if ((confirm_i && (in_i == 2'b00)) || timeout) begin
          timer_d = '0;
          if (credit_q != '0) begin
            pay_amt_d   = credit_q;
            pay_kind_d  = 1'b1;
            credit_d    = '0;
            state_d     = S_PAYOUT;
            pay_valid_d = 1'b1;
            busy_d      = 1'b1;
            out_d       = ST_CANCEL;
          end else begin
            state_d = S_IDLE;
          end
        end else if (state_q == S_ACCUM) begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_VEND: begin
        if (vend_ready_i) begin
          vend_valid_d = 1'b0;
          if (pay_amt_q != '0) begin
            state_d     = S_PAYOUT;
            pay_valid_d = 1'b1;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            out_d   = ST_IDLE;
          end
        end
      end
      S_PAYOUT: begin
        if (pay_ready_i) begin
          pay_valid_d = 1'b0;
          pay_amt_d   = '0;
          state_d     = S_IDLE;
          busy_d      = 1'b0;
          out_d       = ST_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      credit_q     <= '0;
      pay_amt_q    <= '0;
      pay_kind_q   <= 1'b0;
      vend_valid_q <= 1'b0;
      pay_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      out_q        <= ST_IDLE;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      credit_q     <= credit_d;
      pay_amt_q    <= pay_amt_d;
      pay_kind_q   <= pay_kind_d;
      vend_valid_q <= vend_valid_d;
      pay_valid_q  <= pay_valid_d;
      busy_q       <= busy_d;
      out_q        <= out_d;
      timer_q      <= timer_d;
    end
  end

  assign vend_valid_o = vend_valid_q;
  assign pay_valid_o  = pay_valid_q;
  assign pay_amt_o    = pay_amt_q;
  assign pay_kind_o   = pay_kind_q;
  assign credit_o     = credit_q;
  assign busy_o       = busy_q;
  assign out_o        = out_q;

endmodule
